// File: rtl/uart_pkg.sv
// Constants and types shared by the UART RX and TX controllers.
package uart_pkg;

  localparam int unsigned CLK_HZ           = 50_000_000;
  localparam int unsigned BAUD_RATE        = 115_200;
  localparam int unsigned DEFAULT_BAUD_DIV = CLK_HZ / BAUD_RATE;
  localparam int unsigned DATA_BITS        = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

endpackage

// File: rtl/rx_bps_module.sv
// Baud-rate counter: runs while enabled and pulses smp at the mid-bit count.
module rx_bps_module
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV,
  parameter int unsigned HALF_DIV = BAUD_DIV / 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic cnt_en,
  input  logic cnt_clr,
  output logic smp
);

  localparam int unsigned CntW = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(HALF_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_en) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign smp = cnt_en && (cnt_q == CntHalf);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start-bit check, 8 data bits LSB-first, stop-bit check.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV,
  parameter int unsigned HALF_DIV = BAUD_DIV / 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       neg_sig,
  input  logic       RX_Pin_In,
  input  logic       RX_En_Sig,
  output logic [7:0] RX_Data,
  output logic       RX_Done_Sig,
  output logic       Frame_Err
);

  uart_state_e state_q, state_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        rx_meta_q, rx_s_q;
  logic        smp;
  logic        cnt_en;
  logic        cnt_clr;

  // Counter is held at zero in IDLE so START always begins at cnt == 0.
  assign cnt_en  = (state_q != StIdle);
  assign cnt_clr = (state_q == StIdle);

  rx_bps_module #(
    .BAUD_DIV (BAUD_DIV),
    .HALF_DIV (HALF_DIV)
  ) u_rx_bps (
    .CLK     (CLK),
    .RST     (RST),
    .cnt_en  (cnt_en),
    .cnt_clr (cnt_clr),
    .smp     (smp)
  );

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (neg_sig && RX_En_Sig) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (smp) begin
          if (!rx_s_q) begin
            state_d   = StData;
            bit_idx_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (smp) begin
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (smp) begin
          state_d = StIdle;
          if (rx_s_q) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rx_meta_q <= RX_Pin_In;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign RX_Data     = data_q;
  assign RX_Done_Sig = done_q;
  assign Frame_Err   = err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 16 clocks per bit.
module tb_uart_rx_ctrl;

  localparam int unsigned Bd = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_Pin_In = 1'b1;
  logic       RX_En_Sig = 1'b1;
  logic       neg_sig;
  logic [7:0] RX_Data;
  logic       RX_Done_Sig;
  logic       Frame_Err;

  logic prev_q = 1'b1;
  int   cyc = 0;
  int   t0 = 0;
  int   tests = 0;
  int   fails = 0;
  int   both_cnt = 0;
  int   done_cyc_q[$];
  int   err_cyc_q[$];
  logic [7:0] done_dat_q[$];

  uart_rx_ctrl #(
    .BAUD_DIV (Bd),
    .HALF_DIV (Bd / 2)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .neg_sig     (neg_sig),
    .RX_Pin_In   (RX_Pin_In),
    .RX_En_Sig   (RX_En_Sig),
    .RX_Data     (RX_Data),
    .RX_Done_Sig (RX_Done_Sig),
    .Frame_Err   (Frame_Err)
  );

  always #5 CLK = ~CLK;

  // Behavioural falling-edge detector on the raw line.
  always @(posedge CLK) prev_q <= RX_Pin_In;
  assign neg_sig = prev_q & ~RX_Pin_In;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (RX_Done_Sig) begin
      done_cyc_q.push_back(cyc);
      done_dat_q.push_back(RX_Data);
    end
    if (Frame_Err) err_cyc_q.push_back(cyc);
    if (RX_Done_Sig && Frame_Err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_log();
    done_cyc_q.delete();
    done_dat_q.delete();
    err_cyc_q.delete();
  endtask

  // One 10-bit frame; drop_at >= 0 lowers the enable at that data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int drop_at);
    RX_Pin_In = 1'b0;
    t0 = cyc;
    wait_cycles(Bd);
    for (int i = 0; i < 8; i++) begin
      RX_Pin_In = b[i];
      if (i == drop_at) RX_En_Sig = 1'b0;
      wait_cycles(Bd);
    end
    RX_Pin_In = stop;
    wait_cycles(Bd);
  endtask

  initial begin
    int t_first;
    logic [7:0] partial;
    partial = 8'h3C;

    wait_cycles(3);
    check("reset_data", 32'(RX_Data), 32'h0);
    check("reset_done", 32'(RX_Done_Sig), 32'h0);
    check("reset_err", 32'(Frame_Err), 32'h0);
    RST = 1'b0;
    wait_cycles(20);

    // Good frame
    clear_log();
    send_frame(8'h55, 1'b1, -1);
    wait_cycles(4);
    check("good_done_count", 32'(done_cyc_q.size()), 32'd1);
    if (done_cyc_q.size() > 0) begin
      check("good_done_cycle", 32'(done_cyc_q[0] - t0), 32'd154);
      check("good_data", 32'(done_dat_q[0]), 32'h55);
    end
    check("good_err_count", 32'(err_cyc_q.size()), 32'd0);
    check("good_data_held", 32'(RX_Data), 32'h55);

    // False start: 3-cycle glitch
    clear_log();
    RX_Pin_In = 1'b0;
    wait_cycles(3);
    RX_Pin_In = 1'b1;
    wait_cycles(40);
    check("false_done_count", 32'(done_cyc_q.size()), 32'd0);
    check("false_err_count", 32'(err_cyc_q.size()), 32'd0);
    check("false_data", 32'(RX_Data), 32'h55);

    // Framing error
    clear_log();
    send_frame(8'hA3, 1'b0, -1);
    RX_Pin_In = 1'b1;
    wait_cycles(20);
    check("ferr_err_count", 32'(err_cyc_q.size()), 32'd1);
    if (err_cyc_q.size() > 0) check("ferr_err_cycle", 32'(err_cyc_q[0] - t0), 32'd154);
    check("ferr_done_count", 32'(done_cyc_q.size()), 32'd0);
    check("ferr_data", 32'(RX_Data), 32'h55);

    // Back-to-back frames with no idle gap
    clear_log();
    send_frame(8'h00, 1'b1, -1);
    t_first = t0;
    send_frame(8'hFF, 1'b1, -1);
    send_frame(8'h81, 1'b1, -1);
    wait_cycles(4);
    check("b2b_done_count", 32'(done_cyc_q.size()), 32'd3);
    if (done_cyc_q.size() == 3) begin
      check("b2b_first_cycle", 32'(done_cyc_q[0] - t_first), 32'd154);
      check("b2b_data0", 32'(done_dat_q[0]), 32'h00);
      check("b2b_data1", 32'(done_dat_q[1]), 32'hFF);
      check("b2b_data2", 32'(done_dat_q[2]), 32'h81);
      check("b2b_gap01", 32'(done_cyc_q[1] - done_cyc_q[0]), 32'd160);
      check("b2b_gap12", 32'(done_cyc_q[2] - done_cyc_q[1]), 32'd160);
    end
    check("b2b_err_count", 32'(err_cyc_q.size()), 32'd0);

    // Reset in the middle of data bit 4
    clear_log();
    RX_Pin_In = 1'b0;
    wait_cycles(Bd);
    for (int i = 0; i < 4; i++) begin
      RX_Pin_In = partial[i];
      wait_cycles(Bd);
    end
    RX_Pin_In = partial[4];
    wait_cycles(Bd / 2);
    RST = 1'b1;
    RX_Pin_In = 1'b1;
    wait_cycles(1);
    RST = 1'b0;
    check("rst_data_cleared", 32'(RX_Data), 32'h0);
    wait_cycles(200);
    check("rst_no_strobe", 32'(done_cyc_q.size() + err_cyc_q.size()), 32'd0);
    send_frame(8'hC3, 1'b1, -1);
    wait_cycles(4);
    check("rst_done_count", 32'(done_cyc_q.size()), 32'd1);
    check("rst_data", 32'(RX_Data), 32'hC3);

    // Enable gating
    clear_log();
    RX_En_Sig = 1'b0;
    send_frame(8'h12, 1'b1, -1);
    wait_cycles(20);
    check("en_off_done", 32'(done_cyc_q.size()), 32'd0);
    check("en_off_err", 32'(err_cyc_q.size()), 32'd0);
    check("en_off_data", 32'(RX_Data), 32'hC3);
    RX_En_Sig = 1'b1;
    send_frame(8'h34, 1'b1, -1);
    wait_cycles(4);
    check("en_on_done", 32'(done_cyc_q.size()), 32'd1);
    check("en_on_data", 32'(RX_Data), 32'h34);
    clear_log();
    send_frame(8'h56, 1'b1, 3);
    wait_cycles(4);
    check("en_drop_done", 32'(done_cyc_q.size()), 32'd1);
    check("en_drop_data", 32'(RX_Data), 32'h56);
    check("en_drop_err", 32'(err_cyc_q.size()), 32'd0);

    check("strobes_never_both", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
